// File: rtl/fc_pkg.sv
// Shared types, sizing helpers and the per-lane post-processing (bias/shift/saturate/ReLU)
// for the sequential fully-connected layer.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_FINISH = 2'd2
  } fc_state_t;

  // Default Q8.8 operand format.
  localparam int Q_DATA_WIDTH = 16;
  localparam int Q_FRAC_BITS  = 8;

  // Working width of the post-processing datapath; wide enough for any legal accumulator.
  localparam int MAXW = 128;

  function automatic int acc_width(input int data_width, input int input_nodes);
    return 2 * data_width + $clog2(input_nodes) + 1;
  endfunction

  function automatic int idx_width(input int input_nodes);
    return (input_nodes > 1) ? $clog2(input_nodes) : 1;
  endfunction

  // Floor-shift back to the Q format, clamp to the signed data range, optionally ReLU.
  function automatic logic signed [MAXW-1:0] post_process(
    input logic signed [MAXW-1:0] s,
    input int                     dw,
    input int                     frac,
    input logic                   relu
  );
    logic signed [MAXW-1:0] r;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    r  = s >>> frac;
    hi = (MAXW'(1) <<< (dw - 1)) - MAXW'(1);
    lo = -hi - MAXW'(1);
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    if (relu && r[MAXW-1]) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// Start/done handshake and operand/result buses of the fully-connected layer.
interface fc_layer_seq_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int INPUT_NODES  = 4,
  parameter int OUTPUT_NODES = 4
);
  logic                                       start;
  logic [DATA_WIDTH*INPUT_NODES-1:0]          input_fc;
  logic [DATA_WIDTH*INPUT_NODES*OUTPUT_NODES-1:0] weights;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0]         bias;
  logic                                       busy;
  logic                                       done;
  logic                                       out_valid;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0]         output_fc;

  modport master (
    output start, input_fc, weights, bias,
    input  busy, done, out_valid, output_fc
  );

  modport slave (
    input  start, input_fc, weights, bias,
    output busy, done, out_valid, output_fc
  );
endinterface

// File: rtl/fc_mac_lane.sv
// One output neuron: accumulates x*w products, then adds bias and post-processes on finish.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int INPUT_NODES = 4,
  parameter int RELU_EN     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         enable,
  input  logic                         finish,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] w,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic        [DATA_WIDTH-1:0] y
);
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, INPUT_NODES);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_reg;
  logic signed [MAXW-1:0]         acc_ext;
  logic signed [MAXW-1:0]         bias_ext;
  logic signed [MAXW-1:0]         post;

  assign prod     = x * w;
  assign acc_ext  = {{(MAXW-ACC_WIDTH){acc_reg[ACC_WIDTH-1]}}, acc_reg};
  // Bias is in the operand Q format; lift it to the product scale before adding.
  assign bias_ext = {{(MAXW-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} <<< FRAC_BITS;
  assign post     = post_process(acc_ext + bias_ext, DATA_WIDTH, FRAC_BITS, RELU_EN != 0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
      y       <= '0;
    end else begin
      if (clear)
        acc_reg <= '0;
      else if (enable)
        acc_reg <= acc_reg + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
      if (finish)
        y <= post[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/fc_layer_seq.sv
// Sequential fixed-point fully-connected layer: operand latches, index FSM and one MAC lane
// per output neuron; results stay registered until the next run finishes.
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int INPUT_NODES  = 4,
  parameter int OUTPUT_NODES = 4,
  parameter int RELU_EN      = 1
) (
  input logic          clk,
  input logic          reset,
  fc_layer_seq_if.slave bus
);
  localparam int IDX_W = idx_width(INPUT_NODES);

  fc_state_t                                      state_reg;
  logic [IDX_W-1:0]                               index_reg;
  logic [DATA_WIDTH*INPUT_NODES-1:0]              x_reg;
  logic [DATA_WIDTH*INPUT_NODES*OUTPUT_NODES-1:0] w_reg;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0]             b_reg;
  logic                                           busy_reg;
  logic                                           done_reg;
  logic                                           out_valid_reg;

  logic signed [DATA_WIDTH-1:0] x_word [INPUT_NODES];
  logic signed [DATA_WIDTH-1:0] w_word [OUTPUT_NODES][INPUT_NODES];
  logic signed [DATA_WIDTH-1:0] x_cur;
  logic                         lane_clear;
  logic                         lane_enable;
  logic                         lane_finish;

  assign lane_clear  = (state_reg == ST_IDLE) && bus.start;
  assign lane_enable = (state_reg == ST_MAC);
  assign lane_finish = (state_reg == ST_FINISH);
  assign x_cur       = x_word[index_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      index_reg     <= '0;
      x_reg         <= '0;
      w_reg         <= '0;
      b_reg         <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            x_reg         <= bus.input_fc;
            w_reg         <= bus.weights;
            b_reg         <= bus.bias;
            index_reg     <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_MAC;
          end
        end
        ST_MAC: begin
          index_reg <= index_reg + IDX_W'(1);
          if (index_reg == IDX_W'(INPUT_NODES - 1))
            state_reg <= ST_FINISH;
        end
        ST_FINISH: begin
          index_reg     <= '0;
          done_reg      <= 1'b1;
          out_valid_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  genvar gi, gj;
  generate
    for (gj = 0; gj < INPUT_NODES; gj++) begin : g_x
      assign x_word[gj] = x_reg[DATA_WIDTH*gj +: DATA_WIDTH];
    end

    for (gi = 0; gi < OUTPUT_NODES; gi++) begin : g_lane
      for (gj = 0; gj < INPUT_NODES; gj++) begin : g_w
        assign w_word[gi][gj] = w_reg[DATA_WIDTH*(gi*INPUT_NODES+gj) +: DATA_WIDTH];
      end

      fc_mac_lane #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAC_BITS   (FRAC_BITS),
        .INPUT_NODES (INPUT_NODES),
        .RELU_EN     (RELU_EN)
      ) u_lane (
        .clk    (clk),
        .reset  (reset),
        .clear  (lane_clear),
        .enable (lane_enable),
        .finish (lane_finish),
        .x      (x_cur),
        .w      (w_word[gi][index_reg]),
        .bias   (b_reg[DATA_WIDTH*gi +: DATA_WIDTH]),
        .y      (bus.output_fc[DATA_WIDTH*gi +: DATA_WIDTH])
      );
    end
  endgenerate

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.out_valid = out_valid_reg;
endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Parametrised, sequential fixed-point fully-connected layer with a start/done handshake.
- Streams one input activation per cycle to OUTPUT_NODES parallel multiply-accumulate lanes, each with its own weight row.
- After the dot product, each lane adds a per-node bias, optionally applies ReLU and saturates to DATA_WIDTH.
- Sits between feature-extraction stages and the classifier. Results stay registered until the next accepted start.

Parameters:
- DATA_WIDTH, 16, width of every activation, weight, bias and output word (signed two's complement).
- FRAC_BITS, 8, fractional bits of the Q format shared by all operands.
- INPUT_NODES, 4, number of input activations (dot-product length), >=1.
- OUTPUT_NODES, 4, number of output neurons / MAC lanes, >=1.
- RELU_EN, 1, 1 = clamp negative results to 0, 0 = linear output.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request; accepted only in IDLE.
- input_fc  input  DATA_WIDTH*INPUT_NODES  activation j at [DATA_WIDTH*j +: DATA_WIDTH].
- weights  input  DATA_WIDTH*INPUT_NODES*OUTPUT_NODES  w(o,j) at [DATA_WIDTH*(o*INPUT_NODES+j) +: DATA_WIDTH].
- bias  input  DATA_WIDTH*OUTPUT_NODES  bias(o) at [DATA_WIDTH*o +: DATA_WIDTH].
- busy  output  1  high from the cycle after the start edge until done.
- done  output  1  one-cycle pulse when output_fc is updated.
- out_valid  output  1  output_fc holds a completed result.
- output_fc  output  DATA_WIDTH*OUTPUT_NODES  y(o) at [DATA_WIDTH*o +: DATA_WIDTH].

Behaviour:
- Reset: state=IDLE, index=0, accumulators=0, output_fc=0, busy=0, done=0, out_valid=0. Reset mid-run aborts with no done and no output update.
- States: IDLE, MAC, FINISH.
- IDLE, start=1 at edge 0:
  - latch input_fc, weights and bias into internal registers;
  - clear all accumulators; index=0;
  - out_valid=0; busy=1; next state MAC.
- start=0 in IDLE: hold everything.
- MAC, edges 1..INPUT_NODES:
  - every lane: acc(o) += x(index)*w(o,index), full 2*DATA_WIDTH signed product, sign-extended;
  - index increments; processing order is index 0 upward.
  - After index INPUT_NODES-1 has been processed, go to FINISH.
- FINISH, edge INPUT_NODES+1:
  - s = acc(o) + (sign-extended bias(o) << FRAC_BITS);
  - r = s >>> FRAC_BITS (arithmetic shift, floor rounding);
  - saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1];
  - if RELU_EN, negative results become 0;
  - register the result into output_fc;
  - done=1 for exactly this one cycle; out_valid=1; busy=0; next state IDLE.
- Latency: done is high in the cycle following edge INPUT_NODES+1. Total run is INPUT_NODES+1 cycles after the start edge.
- Back-to-back runs: start may be asserted in the cycle done is high. It is accepted at the next edge, which clears out_valid.
- start while busy (MAC or FINISH) is ignored: no restart, no extra done.
- Input changes after the start edge have no effect on the current run.
- Accumulator width: ACC_WIDTH = 2*DATA_WIDTH + clog2(INPUT_NODES) + 1. No overflow is possible before saturation.
- output_fc holds its value across IDLE until the next FINISH.

Decomposition:
- Package fc_pkg:
  - state encoding (IDLE/MAC/FINISH);
  - clog2-based ACC_WIDTH function;
  - saturate-and-shift function shared by all lanes;
  - Q-format helper constants.
- One sub-module, fc_mac_lane, instantiated OUTPUT_NODES times:
  - inputs: clear, enable, x, w, bias, finish strobe;
  - owns its accumulator and post-processing (bias add, shift, saturate, ReLU);
  - outputs its registered y(o).
- The top level holds the FSM, index counter, operand latches and handshake outputs.

Test Plan:
- Defaults, x=[1,2,3,4]*256, row 0 weights all 256, bias 0, start pulsed -> y(0)=2560 (10.0); done high exactly 5 cycles after the start edge; busy high for the 5 intervening cycles.
- Row 1 weights all -256, x as above, bias(1)=0x0600 (6.0) -> RELU_EN=1: y(1)=0. RELU_EN=0: y(1)=0xFC00 (-4.0).
- x all 0x7F00, weights all 0x7F00 -> every y=0x7FFF. With row weights 0x8100 and RELU_EN=0 -> y=0x8000.
- Rounding: x(0)=1, w(0,0)=128, others 0 -> y=0. With w(0,0)=-128 -> y=0xFFFF (floor). Bias 128 with zero inputs -> y=128.
- start re-pulsed at cycles 2 and 4 of a run -> ignored, single done, result unchanged. start asserted in the done cycle -> second run is accepted and out_valid drops at the next edge.
- reset asserted at cycle 2 of a run -> busy/done/out_valid/output_fc = 0 immediately, no done appears. The next start yields the correct result.
